// File: rtl/image_fifo_ram.sv
// Simple dual-port RAM for the image FIFO: one write port and one registered read port.
// rdata is cleared by reset so the FIFO's dout starts at zero.
module image_fifo_ram #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10,
    parameter     RAM_STYLE = "block"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    localparam int DEPTH = 1 << ADDR_BITS;

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // The reset on the output latch maps onto the BRAM's synchronous output reset.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= r_mem[raddr];
    end
endmodule

// File: rtl/image_fifo_thresh.sv
// Single-clock image line/window FIFO on inferred RAM, with registered threshold flags
// (M_Ready/S_Ready), exact occupancy, full/empty and sticky overflow/underflow.
module image_fifo_thresh #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10,
    parameter     RAM_STYLE = "block"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    input  logic [ADDR_BITS:0]   M_count,
    output logic                 M_Ready,
    input  logic [ADDR_BITS:0]   S_count,
    output logic                 S_Ready,
    output logic [ADDR_BITS:0]   data_count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS+1:0] DEPTH_X = (ADDR_BITS+2)'(DEPTH);

    logic [ADDR_BITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_BITS:0]   r_count, w_count_nxt;
    logic [ADDR_BITS+1:0] w_s_sum;
    logic                 w_wr_ok, w_rd_ok;

    // Acceptance uses the registered flags only, never same-cycle requests.
    assign w_wr_ok = wr_en & ~full;
    assign w_rd_ok = rd_en & ~empty;
    assign w_s_sum = {1'b0, r_count} + {1'b0, S_count};
    assign data_count = r_count;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok)      w_count_nxt = r_count + 1'b1;
        else if (w_rd_ok && !w_wr_ok) w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            M_Ready   <= 1'b0;
            S_Ready   <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= w_count_nxt;
            full      <= (w_count_nxt == DEPTH_C);
            empty     <= (w_count_nxt == '0);
            M_Ready   <= (r_count >= M_count);
            S_Ready   <= (w_s_sum <= DEPTH_X);
            overflow  <= (wr_en & full)  | (overflow  & ~err_clr);
            underflow <= (rd_en & empty) | (underflow & ~err_clr);
        end
    end

    image_fifo_ram #(
        .WIDTH    (WIDTH),
        .ADDR_BITS(ADDR_BITS),
        .RAM_STYLE(RAM_STYLE)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (w_wr_ok),
        .waddr(r_wr_ptr),
        .wdata(din),
        .re   (w_rd_ok),
        .raddr(r_rd_ptr),
        .rdata(dout)
    );
endmodule

// File: tb/tb_image_fifo_thresh.sv
// Self-checking bench for image_fifo_thresh: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_image_fifo_thresh;
    localparam int W  = 8;
    localparam int AB = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, err_clr;
    logic [W-1:0]  din, dout;
    logic [AB:0]   M_count, S_count, data_count;
    logic          M_Ready, S_Ready, full, empty, overflow, underflow;

    image_fifo_thresh #(.WIDTH(W), .ADDR_BITS(AB), .RAM_STYLE("block")) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
        .M_count(M_count), .M_Ready(M_Ready), .S_count(S_count), .S_Ready(S_Ready),
        .data_count(data_count), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    bit           m_mrdy, m_srdy, m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit w, input bit r, input logic [W-1:0] d,
                                input bit c, input bit rs, input int mc, input int sc);
        int  cnt;
        bit  was_full, was_empty;
        if (rs) begin
            q.delete();
            m_dout = '0; m_mrdy = 0; m_srdy = 1; m_ovf = 0; m_unf = 0;
        end else begin
            cnt       = q.size();
            was_full  = (cnt == D);
            was_empty = (cnt == 0);
            m_mrdy    = (cnt >= mc);
            m_srdy    = (cnt + sc <= D);
            m_ovf     = (w && was_full)  || (m_ovf && !c);
            m_unf     = (r && was_empty) || (m_unf && !c);
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
    endtask

    task automatic compare_all();
        chk("data_count", data_count, q.size());
        chk("full",       full,       q.size() == D);
        chk("empty",      empty,      q.size() == 0);
        chk("dout",       dout,       m_dout);
        chk("M_Ready",    M_Ready,    m_mrdy);
        chk("S_Ready",    S_Ready,    m_srdy);
        chk("overflow",   overflow,   m_ovf);
        chk("underflow",  underflow,  m_unf);
    endtask

    // One clock: drive, advance model at the edge, compare 1 time unit later.
    task automatic step(input bit w, input bit r, input logic [W-1:0] d,
                        input bit c = 0, input bit rs = 0);
        wr_en = w; rd_en = r; din = d; err_clr = c; rst = rs;
        @(posedge clk);
        model_update(w, r, d, c, rs, int'(M_count), int'(S_count));
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(0, 0, 8'h00, 0, 1);
    endtask

    initial begin
        rst = 1; wr_en = 0; rd_en = 0; err_clr = 0; din = '0;
        M_count = 5'd1; S_count = 5'd16;
        m_dout = '0; m_mrdy = 0; m_srdy = 1; m_ovf = 0; m_unf = 0;

        // Reset and idle
        do_reset();
        step(0, 0, 8'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_empty", empty, 1'b1);
        chk("rst_S_Ready", S_Ready, 1'b1);
        chk("rst_M_Ready", M_Ready, 1'b0);
        M_count = 5'd0;
        step(0, 0, 8'h00);
        chk("mcount0_M_Ready", M_Ready, 1'b1);
        M_count = 5'd1;

        // Fill, overflow, drain in order
        for (int i = 0; i < D; i++) step(1, 0, 8'(i));
        chk("fill_full", full, 1'b1);
        chk("fill_count", data_count, 5'd16);
        step(1, 0, 8'hAA);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", data_count, 5'd16);
        for (int i = 0; i < D; i++) begin
            step(0, 1, 8'h00);
            chk("drain_order", dout, 8'(i));
        end
        step(0, 0, 8'h00, 1);
        chk("ovf_clr", overflow, 1'b0);
        // Second lap exercises pointer wrap
        for (int i = 0; i < D; i++) step(1, 0, 8'(8'h20 + i));
        for (int i = 0; i < D; i++) begin
            step(0, 1, 8'h00);
            chk("wrap_order", dout, 8'(8'h20 + i));
        end

        // Thresholds
        M_count = 5'd9; S_count = 5'd8;
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h40 + i));
        chk("thr_count9", data_count, 5'd9);
        chk("thr_M_lag", M_Ready, 1'b0);
        chk("thr_S_at8", S_Ready, 1'b1);
        step(0, 0, 8'h00);
        chk("thr_M_rise", M_Ready, 1'b1);
        chk("thr_S_at9", S_Ready, 1'b0);
        S_count = 5'd17;
        do_reset();
        step(0, 0, 8'h00);
        chk("thr_S17_empty", S_Ready, 1'b0);
        S_count = 5'd16; M_count = 5'd1;

        // Simultaneous read/write at count 5
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i));
        step(1, 1, 8'h55);
        chk("rw5_count", data_count, 5'd5);
        chk("rw5_dout", dout, 8'h50);
        for (int i = 1; i < 6; i++) begin
            step(0, 1, 8'h00);
            chk("rw5_order", dout, 8'(8'h50 + i));
        end

        // Simultaneous when empty
        do_reset();
        step(1, 1, 8'h77);
        chk("rwE_count", data_count, 5'd1);
        chk("rwE_unf", underflow, 1'b1);
        step(0, 1, 8'h00);
        chk("rwE_dout", dout, 8'h77);

        // Simultaneous when full
        do_reset();
        for (int i = 0; i < D; i++) step(1, 0, 8'(8'h80 + i));
        step(1, 1, 8'h99);
        chk("rwF_count", data_count, 5'd15);
        chk("rwF_ovf", overflow, 1'b1);
        chk("rwF_dout", dout, 8'h80);

        // err_clr vs same-cycle violation: set wins
        step(0, 0, 8'h00, 1);
        chk("clr_both_ovf", overflow, 1'b0);
        chk("clr_both_unf", underflow, 1'b0);
        step(1, 0, 8'hA5);
        step(1, 0, 8'hA6, 1);
        chk("clr_set_wins", overflow, 1'b1);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'hB0 + i));
        chk("mid_count7", data_count, 5'd7);
        do_reset();
        chk("mid_rst_count", data_count, 5'd0);
        chk("mid_rst_empty", empty, 1'b1);
        step(1, 0, 8'hC3);
        step(0, 1, 8'h00);
        chk("mid_rst_first", dout, 8'hC3);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ((n % 200) == 0) begin
                M_count = 5'($urandom_range(0, 18));
                S_count = 5'($urandom_range(0, 18));
            end
            step($urandom_range(0, 99) < ((n / 500) % 2 ? 35 : 65),
                 $urandom_range(0, 99) < ((n / 500) % 2 ? 65 : 35),
                 8'($urandom),
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 399) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
